// File: rtl/pe_ctrl_seq_pkg.sv
// Shared constants for the PE control sequencer: opcodes, FSM encoding and control-word width.
// Consumers import pe_ctrl_seq_pkg::*.
package pe_ctrl_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACC   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_WB    = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int OP_NOP  = 0;
  localparam int OP_MACC = 1;

  // push, pop, flush, write_valid, write_req, read_req, enable
  localparam int CTRL_FLAG_BITS = 7;

  function automatic int ctrl_width(input int addr_w, input int op_w);
    return 2 * addr_w + op_w + CTRL_FLAG_BITS;
  endfunction

endpackage

// File: rtl/pe_ctrl_seq_if.sv
// Sequencer bus: start/config/stall towards the sequencer, ctrl/busy/done back out.
// master = requester side, slave = sequencer side.
interface pe_ctrl_seq_if #(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int OP_CODE_WIDTH     = 3,
  parameter int CNT_WIDTH         = 16
);
  import pe_ctrl_seq_pkg::*;

  localparam int CTRL_WIDTH = ctrl_width(PE_BUF_ADDR_WIDTH, OP_CODE_WIDTH);

  logic                         start;
  logic [CNT_WIDTH-1:0]         cfg_acc_len;
  logic [CNT_WIDTH-1:0]         cfg_num_out;
  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_rd_base;
  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_wr_base;
  logic                         stall;
  logic [CTRL_WIDTH-1:0]        ctrl;
  logic                         busy;
  logic                         done;

  modport master (
    output start, cfg_acc_len, cfg_num_out, cfg_rd_base, cfg_wr_base, stall,
    input  ctrl, busy, done
  );

  modport slave (
    input  start, cfg_acc_len, cfg_num_out, cfg_rd_base, cfg_wr_base, stall,
    output ctrl, busy, done
  );

endinterface

// File: rtl/pe_ctrl_seq.sv
// PE control sequencer: per output, L MACC reads, one flush, one write-back; registered ctrl word.
// Optional feature macro: PE_NORM_FIFO_EN (norm FIFO push on write-back, pop on done).
module pe_ctrl_seq
  import pe_ctrl_seq_pkg::*;
#(
  parameter int PE_BUF_ADDR_WIDTH = 10,
  parameter int OP_CODE_WIDTH     = 3,
  parameter int CNT_WIDTH         = 16
) (
  input  logic          clk,
  input  logic          reset,
  pe_ctrl_seq_if.slave  bus
);

  localparam int CW = ctrl_width(PE_BUF_ADDR_WIDTH, OP_CODE_WIDTH);
  localparam logic [CNT_WIDTH-1:0]         CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [PE_BUF_ADDR_WIDTH-1:0] ADDR_ONE = PE_BUF_ADDR_WIDTH'(1);

`ifdef PE_NORM_FIFO_EN
  localparam logic NORM_FIFO_EN = 1'b1;
`else
  localparam logic NORM_FIFO_EN = 1'b0;
`endif

  logic [2:0]                   state_q, state_d;
  logic [CNT_WIDTH-1:0]         acc_len_q, acc_len_d;
  logic [CNT_WIDTH-1:0]         num_out_q, num_out_d;
  logic [CNT_WIDTH-1:0]         acc_cnt_q, acc_cnt_d;
  logic [CNT_WIDTH-1:0]         out_cnt_q, out_cnt_d;
  logic [PE_BUF_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [PE_BUF_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0]                ctrl_q, ctrl_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic                         f_push, f_pop, f_flush, f_wvalid, f_wreq, f_rreq, f_en;
  logic [PE_BUF_ADDR_WIDTH-1:0] f_rd_addr, f_wr_addr;
  logic [OP_CODE_WIDTH-1:0]     f_op;

  always_comb begin
    state_d   = state_q;
    acc_len_d = acc_len_q;
    num_out_d = num_out_q;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    f_push    = 1'b0;
    f_pop     = 1'b0;
    f_flush   = 1'b0;
    f_wvalid  = 1'b0;
    f_wreq    = 1'b0;
    f_rreq    = 1'b0;
    f_en      = 1'b0;
    f_rd_addr = '0;
    f_wr_addr = '0;
    f_op      = OP_CODE_WIDTH'(OP_NOP);

    // A stall outside IDLE freezes everything and inserts an all-zero word.
    if (bus.stall && state_q != ST_IDLE) begin
      busy_d = (state_q != ST_DONE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            acc_len_d = (bus.cfg_acc_len == '0) ? CNT_ONE : bus.cfg_acc_len;
            num_out_d = bus.cfg_num_out;
            rd_addr_d = bus.cfg_rd_base;
            wr_addr_d = bus.cfg_wr_base;
            acc_cnt_d = '0;
            out_cnt_d = '0;
            state_d   = (bus.cfg_num_out == '0) ? ST_DONE : ST_ACC;
          end
        end
        ST_ACC: begin
          busy_d    = 1'b1;
          f_en      = 1'b1;
          f_rreq    = 1'b1;
          f_op      = OP_CODE_WIDTH'(OP_MACC);
          f_rd_addr = rd_addr_q;
          rd_addr_d = rd_addr_q + ADDR_ONE;
          if (acc_cnt_q == acc_len_q - CNT_ONE) begin
            acc_cnt_d = '0;
            state_d   = ST_FLUSH;
          end else begin
            acc_cnt_d = acc_cnt_q + CNT_ONE;
          end
        end
        ST_FLUSH: begin
          busy_d  = 1'b1;
          f_flush = 1'b1;
          state_d = ST_WB;
        end
        ST_WB: begin
          busy_d    = 1'b1;
          f_wreq    = 1'b1;
          f_wvalid  = 1'b1;
          f_push    = NORM_FIFO_EN;
          f_wr_addr = wr_addr_q;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          out_cnt_d = out_cnt_q + CNT_ONE;
          state_d   = (out_cnt_q == num_out_q - CNT_ONE) ? ST_DONE : ST_ACC;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          f_pop   = NORM_FIFO_EN;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    ctrl_d = {f_push, f_pop, f_rd_addr, f_wr_addr, f_flush,
              f_wvalid, f_wreq, f_rreq, f_en, f_op};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      acc_len_q <= '0;
      num_out_q <= '0;
      acc_cnt_q <= '0;
      out_cnt_q <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      ctrl_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_len_q <= acc_len_d;
      num_out_q <= num_out_d;
      acc_cnt_q <= acc_cnt_d;
      out_cnt_q <= out_cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      ctrl_q    <= ctrl_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ctrl = ctrl_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Testbench for pe_ctrl_seq: reference word list built from the sequence rules, replayed
// cycle by cycle with stall insertion and compared against ctrl/busy/done.
module tb_pe_ctrl_seq;

  localparam int AW   = 10;
  localparam int OPW  = 3;
  localparam int CNTW = 16;
  localparam int CW   = 2 * AW + OPW + 7;

`ifdef PE_NORM_FIFO_EN
  localparam logic FIFO_EN = 1'b1;
`else
  localparam logic FIFO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pe_ctrl_seq_if #(.PE_BUF_ADDR_WIDTH(AW), .OP_CODE_WIDTH(OPW), .CNT_WIDTH(CNTW)) bus ();

  pe_ctrl_seq #(.PE_BUF_ADDR_WIDTH(AW), .OP_CODE_WIDTH(OPW), .CNT_WIDTH(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [CW-1:0] exp_q[$];

  function automatic logic [CW-1:0] mk_word(input logic push, input logic pop, input int rd,
                                            input int wr, input logic flush, input logic wv,
                                            input logic wreq, input logic rreq, input logic en,
                                            input int op);
    logic [AW-1:0]  rd_v;
    logic [AW-1:0]  wr_v;
    logic [OPW-1:0] op_v;
    rd_v = AW'(rd % (1 << AW));
    wr_v = AW'(wr % (1 << AW));
    op_v = OPW'(op);
    return {push, pop, rd_v, wr_v, flush, wv, wreq, rreq, en, op_v};
  endfunction

  // Expected word list: for each output, L MACC reads, a flush, a write-back.
  function automatic void build_model(input int l, input int n, input int rb, input int wb);
    int le;
    le = (l == 0) ? 1 : l;
    exp_q.delete();
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < le; k++)
        exp_q.push_back(mk_word(1'b0, 1'b0, rb + j * le + k, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1));
      exp_q.push_back(mk_word(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      exp_q.push_back(mk_word(FIFO_EN, 1'b0, 0, wb + j, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    end
  endfunction

  task automatic run_seq(input string name, input int l, input int n, input int rb,
                         input int wb, input logic [63:0] stall_mask);
    int n_words;
    int p;
    int c;
    logic [CW-1:0] exp_ctrl;
    logic exp_busy;
    logic exp_done;
    logic [CW-1:0] done_word;
    build_model(l, n, rb, wb);
    n_words = exp_q.size();
    done_word = mk_word(1'b0, FIFO_EN, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.cfg_acc_len = CNTW'(l);
    bus.cfg_num_out = CNTW'(n);
    bus.cfg_rd_base = AW'(rb);
    bus.cfg_wr_base = AW'(wb);
    bus.stall       = stall_mask[0];
    @(posedge clk);
    p = 0;
    c = 1;
    while (p <= n_words) begin
      if (c >= 64) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: done not reached by cycle %0d, words left=%0d", name, c, n_words - p);
        break;
      end
      @(negedge clk);
      // Config and start churn mid-sequence must not disturb a running sequence.
      bus.start       = 1'($urandom_range(0, 1));
      bus.stall       = stall_mask[c];
      bus.cfg_acc_len = CNTW'($urandom);
      bus.cfg_num_out = CNTW'($urandom);
      bus.cfg_rd_base = AW'($urandom);
      bus.cfg_wr_base = AW'($urandom);
      @(posedge clk);
      #1;
      exp_busy = (p < n_words);
      if (stall_mask[c]) begin
        exp_ctrl = '0;
        exp_done = 1'b0;
      end else begin
        exp_ctrl = (p < n_words) ? exp_q[p] : done_word;
        exp_done = (p == n_words);
        p++;
      end
      checks++;
      if (bus.ctrl !== exp_ctrl) begin
        failures++;
        $display("FAIL %s ctrl cyc%0d got=%h exp=%h", name, c, bus.ctrl, exp_ctrl);
      end
      checks++;
      if (bus.busy !== exp_busy) begin
        failures++;
        $display("FAIL %s busy cyc%0d got=%b exp=%b", name, c, bus.busy, exp_busy);
      end
      checks++;
      if (bus.done !== exp_done) begin
        failures++;
        $display("FAIL %s done cyc%0d got=%b exp=%b", name, c, bus.done, exp_done);
      end
      c++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stall = 1'b0;
    $display("seq %s L=%0d N=%0d rd=%h wr=%h cycles=%0d", name, l, n, rb, wb, c - 1);
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.ctrl !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL %s idle ctrl/busy/done got=%h/%b/%b exp=0/0/0", name, bus.ctrl, bus.busy, bus.done);
      end
    end
    $display("idle %s %0d cycles", name, cycles);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.cfg_acc_len = '0;
    bus.cfg_num_out = '0;
    bus.cfg_rd_base = '0;
    bus.cfg_wr_base = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ctrl !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset ctrl/busy/done got=%h/%b/%b exp=0/0/0", bus.ctrl, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    check_idle("after_reset", 2);
  endtask

  task automatic test_basic();
    run_seq("basic", 3, 2, 'h10, 'h20, 64'h0);
  endtask

  task automatic test_stall();
    logic [63:0] m;
    m = 64'h0;
    m[4] = 1'b1;
    m[5] = 1'b1;
    run_seq("stall", 3, 2, 'h10, 'h20, m);
  endtask

  task automatic test_wrap();
    run_seq("wrap", 4, 1, 'h3FE, 'h3FF, 64'h0);
  endtask

  task automatic test_zero_out();
    run_seq("zero_out", 3, 0, 'h55, 'h66, 64'h0);
    check_idle("zero_out", 2);
  endtask

  task automatic test_zero_len();
    run_seq("zero_len", 0, 1, 'h7, 'h9, 64'h0);
  endtask

  task automatic test_fifo();
    run_seq("fifo", 1, 3, 'h100, 'h200, 64'h0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_acc_len = CNTW'(5);
    bus.cfg_num_out = CNTW'(2);
    bus.cfg_rd_base = AW'('h40);
    bus.cfg_wr_base = AW'('h50);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ctrl !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset ctrl/busy/done got=%h/%b/%b exp=0/0/0", bus.ctrl, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    check_idle("mid_reset", 2);
    run_seq("after_mid_reset", 2, 2, 'h30, 'h31, 64'h0);
  endtask

  task automatic test_start_with_stall();
    logic [63:0] m;
    m = 64'h1;
    m[2] = 1'b1;
    run_seq("start_stall", 2, 1, 'h11, 'h22, m);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_a", 2, 2, 'h3FF, 'h3FF, 64'h0);
    run_seq("b2b_b", 1, 1, 'h0, 'h1, 64'h0);
  endtask

  task automatic test_random();
    logic [63:0] m;
    for (int it = 0; it < 12; it++) begin
      m = 64'h0;
      for (int b = 0; b < 40; b++)
        m[b] = ($urandom_range(0, 3) == 0);
      run_seq("random", $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 1023), $urandom_range(0, 1023), m);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_out();
    test_zero_len();
    test_fifo();
    test_mid_reset();
    test_start_with_stall();
    test_back_to_back();
    test_random();
    check_idle("final", 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
